// File: rtl/distance_display_mux.sv
// distance_display_mux
//   Captures a binary distance on a load strobe and converts it to BCD with
//   a sequential double-dabble engine. Multiplexes NUM_DIGITS common-anode
//   seven-segment digits. Also drives a near-object alarm LED and a servo
//   gate command with hysteresis.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   distance in   [IN_WIDTH-1:0] binary distance in cm, unsigned
//   load     in   one-cycle strobe: sample distance, start conversion
//   sseg     out  [0:6] segments a..g, active-low
//   anodos   out  [NUM_DIGITS-1:0] digit selects, active-low, bit 0 = units
//   busy     out  high while a conversion is in progress
//   led      out  high while latched distance < ALARM_CM
//   outservo out  servo command, 1 = open, 0 = closed
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant nonzero digit are blanked.
//   Digit 0 and the overflow dash are never blanked.
module distance_display_mux #(
    parameter int NUM_DIGITS  = 6,
    parameter int IN_WIDTH    = 20,
    parameter int REFRESH_DIV = 50000,
    parameter int ALARM_CM    = 100,
    parameter int CLOSE_CM    = 10,
    parameter int OPEN_CM     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   distance,
    input  logic                  load,
    output logic [0:6]            sseg,
    output logic [NUM_DIGITS-1:0] anodos,
    output logic                  busy,
    output logic                  led,
    output logic                  outservo
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t                state_r;
    logic [IN_WIDTH-1:0]   bin_r;
    logic [IN_WIDTH-1:0]   val_r;
    logic [BCD_W-1:0]      bcd_r;
    logic                  ovf_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [BCD_W-1:0]      disp_r;
    logic [PRE_W-1:0]      pre_r;
    logic [IDX_W-1:0]      idx_r;

    logic [BCD_W-1:0]      bcd_adj_s;
    logic [BCD_W:0]        shifted_s;
    logic [31:0]           val_ext_s;
    logic [NUM_DIGITS-1:0] blank_s;
    logic [3:0]            cur_nib_s;
    logic                  cur_blank_s;

    // Seven-segment decoder; 4'hF is the internal dash code, anything else unused is blank
    function automatic logic [0:6] seg_decode(input logic [3:0] nib);
        logic [0:6] s;
        case (nib)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            4'hF:    s = 7'b1111110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
    end

    // Bit BCD_W of the shifted word leaves the accumulator: a carry into a
    // digit we do not have, i.e. the value is 10^NUM_DIGITS or more.
    assign shifted_s = {bcd_adj_s, bin_r[IN_WIDTH-1]};
    assign val_ext_s = 32'(val_r);

    // Conversion FSM with registered busy, display register, led and servo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            bin_r    <= '0;
            val_r    <= '0;
            bcd_r    <= '0;
            ovf_r    <= 1'b0;
            cnt_r    <= '0;
            disp_r   <= '0;
            busy     <= 1'b0;
            led      <= 1'b0;
            outservo <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        bin_r   <= distance;
                        val_r   <= distance;
                        bcd_r   <= '0;
                        ovf_r   <= 1'b0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_r <= shifted_s[BCD_W-1:0];
                    ovf_r <= ovf_r | shifted_s[BCD_W];
                    bin_r <= bin_r << 1;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(IN_WIDTH - 1)) begin
                        state_r <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (ovf_r) begin
                        disp_r <= {NUM_DIGITS{4'hF}};
                    end else begin
                        disp_r <= bcd_r;
                    end
                    led <= ~ovf_r & (val_ext_s < 32'(ALARM_CM));
                    // Between CLOSE_CM and OPEN_CM the servo keeps its state
                    if (~ovf_r && (val_ext_s < 32'(CLOSE_CM))) begin
                        outservo <= 1'b0;
                    end else if (ovf_r || (val_ext_s >= 32'(OPEN_CM))) begin
                        outservo <= 1'b1;
                    end
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Leading-zero blank mask: digit i blanks when it and all digits above are zero
    always_comb begin
        blank_s = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic hi_zero;
            hi_zero = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                hi_zero    = hi_zero & (disp_r[4*i +: 4] == 4'd0);
                blank_s[i] = hi_zero;
            end
        end
`else
        blank_s = '0;
`endif
    end

    // Select the nibble and blank flag of the currently scanned digit
    always_comb begin
        cur_nib_s   = 4'd0;
        cur_blank_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                cur_nib_s   = disp_r[4*i +: 4];
                cur_blank_s = blank_s[i];
            end else begin
                cur_nib_s   = cur_nib_s;
                cur_blank_s = cur_blank_s;
            end
        end
    end

    // Free-running refresh prescaler and scan index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= '0;
            idx_r <= '0;
        end else begin
            if (pre_r == PRE_W'(REFRESH_DIV - 1)) begin
                pre_r <= '0;
                if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
        end
    end

    // Select and segments registered together so they always change on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anodos <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
            sseg   <= 7'b0000001;
        end else begin
            anodos <= ~(NUM_DIGITS'(1) << idx_r);
            if (cur_blank_s) begin
                sseg <= 7'b1111111;
            end else begin
                sseg <= seg_decode(cur_nib_s);
            end
        end
    end

endmodule

// File: tb/tb_distance_display_mux.sv
module tb_distance_display_mux;

    localparam int ND    = 6;
    localparam int IW    = 20;
    localparam int RD    = 4;
    localparam int ALARM = 100;
    localparam int CLOSE = 10;
    localparam int OPEN  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [IW-1:0] distance = '0;
    logic [0:6]    sseg;
    logic [ND-1:0] anodos;
    logic          busy, led, outservo;

    int n_checks = 0;
    int n_fail   = 0;

    distance_display_mux #(
        .NUM_DIGITS(ND), .IN_WIDTH(IW), .REFRESH_DIV(RD),
        .ALARM_CM(ALARM), .CLOSE_CM(CLOSE), .OPEN_CM(OPEN)
    ) dut (
        .clk(clk), .rst(rst), .distance(distance), .load(load),
        .sseg(sseg), .anodos(anodos), .busy(busy), .led(led), .outservo(outservo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected segments for digit i when the display holds val (or overflow)
    function automatic logic [6:0] model_seg(input int val, input bit ovf, input int i);
        if (ovf) return 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && val < pow10(i)) return 7'b1111111;
`endif
        return pat((val / pow10(i)) % 10);
    endfunction

    int            m_pre, m_idx, m_rem, m_cap, m_val;
    bit            m_busy, m_ovf, m_led, m_servo;
    logic [ND-1:0] exp_an;
    logic [6:0]    exp_seg;

    // Model: outputs registered from the state before each edge; latch IW+1 edges after load edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pre = 0; m_idx = 0; m_rem = 0; m_cap = 0; m_val = 0;
            m_busy = 0; m_ovf = 0; m_led = 0; m_servo = 1;
            exp_an = ~ND'(1); exp_seg = 7'b0000001;
        end else begin
            exp_an  = ~(ND'(1) << m_idx);
            exp_seg = model_seg(m_val, m_ovf, m_idx);
            if (m_pre == RD - 1) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % ND;
            end else begin
                m_pre++;
            end
            if (!m_busy) begin
                if (load) begin
                    m_busy = 1; m_rem = IW + 1; m_cap = int'(distance);
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_val  = m_cap;
                    m_ovf  = (m_cap >= pow10(ND));
                    m_led  = !m_ovf && (m_cap < ALARM);
                    if (!m_ovf && m_cap < CLOSE) m_servo = 0;
                    else if (m_ovf || m_cap >= OPEN) m_servo = 1;
                end
            end
        end
    end

    // Every-cycle compare, away from the active edge
    always @(negedge clk) begin
        check("anodos",   32'(anodos),   32'(exp_an));
        check("sseg",     32'(sseg),     32'(exp_seg));
        check("busy",     32'(busy),     32'(m_busy));
        check("led",      32'(led),      32'(m_led));
        check("outservo", 32'(outservo), 32'(m_servo));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse load, optionally a second pulse at busy-cycle 'second_at', return busy length
    task automatic load_and_count(input int val, input int second_at, input int second_val,
                                  output int cnt);
        @(posedge clk); #1;
        distance = IW'(val); load = 1'b1;
        step(1);
        load = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == second_at) begin
                distance = IW'(second_val); load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step(1);
            cnt++;
        end
        load = 1'b0;
    endtask

    task automatic check_digit(input string name, input logic [ND-1:0] an, input logic [6:0] exp);
        int k = 0;
        while (anodos !== an && k < 40) begin
            step(1);
            k++;
        end
        check({name, "_sel"}, 32'(anodos), 32'(an));
        check(name, 32'(sseg), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int hyst_val [5]  = '{15, 9, 11, 12, 11};
        bit hyst_serv [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        step(3);
        check("rst_anodos", 32'(anodos), 32'(6'b111110));
        check("rst_sseg",   32'(sseg),   32'(7'b0000001));
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_led",    32'(led),    32'd0);
        check("rst_servo",  32'(outservo), 32'd1);
        rst = 1'b0;
        step(30);

        // Pin the model itself with hand-computed values
        check("model_d3_98765", 32'(model_seg(98765, 0, 3)), 32'(7'b0000000));
        check("model_d0_98765", 32'(model_seg(98765, 0, 0)), 32'(7'b0100100));
        check("model_ovf",      32'(model_seg(0, 1, 4)),     32'(7'b1111110));

        // Main conversion
        load_and_count(98765, -1, 0, c);
        check("busy_len_98765", 32'(c), 32'd21);
        check("led_98765",   32'(led),      32'd0);
        check("servo_98765", 32'(outservo), 32'd1);
        check_digit("dig3_98765", 6'b110111, 7'b0000000);
        check_digit("dig4_98765", 6'b101111, 7'b0000100);
`ifdef LEADING_ZERO_BLANK_EN
        check_digit("dig5_98765", 6'b011111, 7'b1111111);
`else
        check_digit("dig5_98765", 6'b011111, 7'b0000001);
`endif

        // Hysteresis sequence
        for (int i = 0; i < 5; i++) begin
            load_and_count(hyst_val[i], -1, 0, c);
            check("hyst_busy_len", 32'(c), 32'd21);
            check("hyst_servo", 32'(outservo), 32'(hyst_serv[i]));
            check("hyst_led",   32'(led),      32'd1);
        end

        // Overflow
        load_and_count(1000000, -1, 0, c);
        check("ovf_led",   32'(led),      32'd0);
        check("ovf_servo", 32'(outservo), 32'd1);
        check_digit("ovf_dig5", 6'b011111, 7'b1111110);
        check_digit("ovf_dig0", 6'b111110, 7'b1111110);

        // Load while busy is dropped
        load_and_count(42, 4, 7, c);
        check("drop_busy_len", 32'(c), 32'd21);
        check("drop_servo", 32'(outservo), 32'd1);
        check("drop_led",   32'(led),      32'd1);
        check_digit("drop_dig1", 6'b111101, 7'b1001100);
        check_digit("drop_dig0", 6'b111110, 7'b0010010);
`ifdef LEADING_ZERO_BLANK_EN
        check_digit("drop_dig2", 6'b111011, 7'b1111111);
`else
        check_digit("drop_dig2", 6'b111011, 7'b0000001);
`endif

        // Reset in the middle of SHIFT
        @(posedge clk); #1;
        distance = IW'(123456); load = 1'b1;
        step(1);
        load = 1'b0;
        step(5);
        rst = 1'b1;
        #1;
        check("abort_busy",   32'(busy),     32'd0);
        check("abort_sseg",   32'(sseg),     32'(7'b0000001));
        check("abort_anodos", 32'(anodos),   32'(6'b111110));
        check("abort_servo",  32'(outservo), 32'd1);
        step(2);
        rst = 1'b0;
        step(30);

        // Randomized loads, some landing while busy
        for (int i = 0; i < 80; i++) begin
            int v;
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 20));
                1:       v = int'($urandom_range(0, 200));
                2:       v = int'($urandom_range(0, 999999));
                default: v = int'($urandom_range(1000000, (1 << IW) - 1));
            endcase
            @(posedge clk); #1;
            distance = IW'(v); load = 1'b1;
            step(1);
            load = 1'b0;
            step(int'($urandom_range(0, 40)));
        end
        step(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
